// File: rtl/bit_stuffer.sv
// USB bit-stuffing stage: inserts a 0 after every MAX_ONES consecutive 1s,
// back-pressuring the upstream CRC stage while the stuffed bit goes out.
module bit_stuffer #(
    parameter int MAX_ONES = 6,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in,
    input  logic             start_b,
    input  logic             endr_b,
    output logic             pause,
    output logic             s_out,
    output logic             out_valid,
    output logic             start_o,
    output logic             endr_o,
    output logic [CNT_W-1:0] stuff_cnt,
    output logic             err
);
    localparam int ONES_W = $clog2(MAX_ONES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STUFF = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic              last_q, last_d;
    logic              s_out_q, s_out_d;
    logic              vld_q, vld_d;
    logic              start_q, start_d;
    logic              endr_q, endr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              consume;
    logic [ONES_W-1:0] run;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            ones_q  <= '0;
            last_q  <= 1'b0;
            s_out_q <= 1'b0;
            vld_q   <= 1'b0;
            start_q <= 1'b0;
            endr_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            last_q  <= last_d;
            s_out_q <= s_out_d;
            vld_q   <= vld_d;
            start_q <= start_d;
            endr_q  <= endr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        s_out_d = 1'b0;
        vld_d   = 1'b0;
        start_d = 1'b0;
        endr_d  = 1'b0;
        err_d   = 1'b0;
        consume = 1'b0;
        run     = '0;

        case (state_q)
            IDLE: begin
                if (start_b) begin
                    consume = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    run     = s_in ? ONES_W'(1) : '0;
                end
            end
            SEND: begin
                consume = 1'b1;
                err_d   = start_b;
                run     = s_in ? ones_q + ONES_W'(1) : '0;
            end
            STUFF: begin
                // Upstream is holding its next bit; emit the stuffed 0 instead.
                err_d   = start_b;
                vld_d   = 1'b1;
                ones_d  = '0;
                cnt_d   = sat_inc(cnt_q);
                endr_d  = last_q;
                state_d = last_q ? IDLE : SEND;
            end
            default: state_d = IDLE;
        endcase

        if (consume) begin
            s_out_d = s_in;
            vld_d   = 1'b1;
            ones_d  = run;
            if (run == ONES_W'(MAX_ONES)) begin
                state_d = STUFF;
                last_d  = endr_b;
            end else if (endr_b) begin
                state_d = IDLE;
                endr_d  = 1'b1;
            end else begin
                state_d = SEND;
            end
        end
    end

    assign pause     = (state_q == STUFF);
    assign s_out     = s_out_q;
    assign out_valid = vld_q;
    assign start_o   = start_q;
    assign endr_o    = endr_q;
    assign stuff_cnt = cnt_q;
    assign err       = err_q;
endmodule

// File: tb/tb_bit_stuffer.sv
// Bench for bit_stuffer: directed and random packets compared against a
// queue-based model of the stuffed output stream.
module tb_bit_stuffer;
    localparam int MAX_ONES = 6;
    localparam int CNT_W    = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_in;
    logic             start_b;
    logic             endr_b;
    logic             pause;
    logic             s_out;
    logic             out_valid;
    logic             start_o;
    logic             endr_o;
    logic [CNT_W-1:0] stuff_cnt;
    logic             err;

    bit_stuffer #(.MAX_ONES(MAX_ONES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .start_b(start_b), .endr_b(endr_b),
        .pause(pause), .s_out(s_out), .out_valid(out_valid), .start_o(start_o),
        .endr_o(endr_o), .stuff_cnt(stuff_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // One output-stream element: bit, start, end, pause seen with it, err seen with it.
    typedef struct packed {
        logic b;
        logic s;
        logic e;
        logic p;
        logic er;
    } ev_t;

    logic pkt_q[$];
    ev_t  exp_q[$];
    ev_t  got_q[$];
    int   exp_stuffs;
    int   n_asrt = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_asrt++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load_bits(input logic [63:0] v, input int n);
        logic [63:0] tmp;
        tmp = v;
        pkt_q.delete();
        for (int i = n - 1; i >= 0; i--) pkt_q.push_back(tmp[i]);
    endtask

    // Expected stuffed stream: a 0 follows every run of MAX_ONES ones.
    task automatic build_model(input int err_at);
        int  run;
        int  last;
        ev_t ev;
        run = 0;
        last = pkt_q.size() - 1;
        exp_q.delete();
        exp_stuffs = 0;
        for (int i = 0; i <= last; i++) begin
            ev.b  = pkt_q[i];
            ev.s  = (i == 0);
            ev.er = (i == err_at);
            ev.p  = 1'b0;
            ev.e  = 1'b0;
            run = pkt_q[i] ? run + 1 : 0;
            if (run == MAX_ONES) begin
                ev.p = 1'b1;
                exp_q.push_back(ev);
                ev = '{b: 1'b0, s: 1'b0, e: (i == last), p: 1'b0, er: 1'b0};
                exp_q.push_back(ev);
                exp_stuffs++;
                run = 0;
            end else begin
                ev.e = (i == last);
                exp_q.push_back(ev);
            end
        end
    endtask

    task automatic run_pkt(input string tag, input int err_at);
        int n, idx, guard, tail, err_cnt, pause_cnt, stray, nmin;
        int exp_cnt;
        build_model(err_at);
        n = pkt_q.size();
        idx = 0; guard = 0; tail = 0; err_cnt = 0; pause_cnt = 0; stray = 0;
        got_q.delete();
        while (tail < 3 && guard < 4 * n + 40) begin
            @(negedge clk);
            guard++;
            if (out_valid) got_q.push_back('{b: s_out, s: start_o, e: endr_o, p: pause, er: err});
            else if (start_o || endr_o) stray++;
            if (err) err_cnt++;
            if (pause) pause_cnt++;
            if (idx < n) begin
                s_in    = pkt_q[idx];
                start_b = !pause && ((idx == 0) || (idx == err_at));
                endr_b  = (idx == n - 1);
                if (!pause) idx++;
            end else begin
                s_in = 1'b0; start_b = 1'b0; endr_b = 1'b0;
            end
            if (idx == n && got_q.size() >= exp_q.size()) tail++;
        end
        chk({tag, " timeout"}, 64'(tail >= 3), 64'd1);
        chk({tag, " length"}, 64'(got_q.size()), 64'(exp_q.size()));
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++)
            chk($sformatf("%s elem%0d{b,s,e,p,err}", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, " pause cycles"}, 64'(pause_cnt), 64'(exp_stuffs));
        chk({tag, " err pulses"}, 64'(err_cnt), 64'(err_at >= 0 ? 1 : 0));
        chk({tag, " stray framing"}, 64'(stray), 64'd0);
        exp_cnt = (exp_stuffs > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : exp_stuffs;
        chk({tag, " stuff_cnt"}, 64'(stuff_cnt), 64'(exp_cnt));
    endtask

    initial begin
        int n, err_at, g, seen, idx;
        rst_n = 1'b1; s_in = 1'b0; start_b = 1'b0; endr_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", 64'({pause, s_out, out_valid, start_o, endr_o, err, stuff_cnt}), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);

        load_bits(64'b0000_0001, 8);            run_pkt("sync", -1);
        load_bits(64'hFF, 8);                   run_pkt("ones8", -1);
        load_bits(64'hFFF, 12);                 run_pkt("ones12", -1);
        load_bits(64'b1111_1011_1111, 12);      run_pkt("broken_run", -1);
        load_bits(64'b1, 1);                    run_pkt("one_bit", -1);
        load_bits(64'b1011_0111_1110_01, 14);   run_pkt("err_mid", 5);
        pkt_q.delete();
        for (int i = 0; i < 7 * 64; i++) pkt_q.push_back(1'b1);
        run_pkt("saturate", -1);

        // Reset asserted during the second stuff cycle of a twelve-ones packet.
        load_bits(64'hFFF, 12);
        g = 0; seen = 0; idx = 0;
        while (seen < 2 && g < 60) begin
            @(negedge clk);
            g++;
            if (pause) seen++;
            if (seen < 2) begin
                if (idx < 12) begin
                    s_in = 1'b1; start_b = !pause && (idx == 0); endr_b = (idx == 11);
                    if (!pause) idx++;
                end else begin
                    s_in = 1'b0; start_b = 1'b0; endr_b = 1'b0;
                end
            end
        end
        chk("mid-reset reached stuff", 64'(seen), 64'd2);
        chk("mid-reset stuff_cnt before", 64'(stuff_cnt), 64'd1);
        #2 rst_n = 1'b1;
        #1 chk("mid-reset outputs", 64'({pause, s_out, out_valid, start_o, endr_o, err, stuff_cnt}), 64'd0);
        s_in = 1'b0; start_b = 1'b0; endr_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("post-reset idle", 64'({pause, out_valid, endr_o}), 64'd0);
        load_bits(64'hFF, 8);                   run_pkt("after_reset", -1);

        for (int k = 0; k < 30; k++) begin
            n = $urandom_range(1, 40);
            pkt_q.delete();
            for (int i = 0; i < n; i++) pkt_q.push_back(logic'($urandom_range(0, 3) != 0));
            err_at = (n > 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : -1;
            run_pkt($sformatf("rand%0d", k), err_at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_stuffer.md
Name: bit_stuffer

Overview:
Serial USB bit-stuffing stage. It sits directly downstream of the CRC stage and upstream of the NRZI encoder. It takes the CRC stage's packet bitstream, one bit per cycle, and inserts a 0 after every run of MAX_ONES consecutive 1s. It back-pressures the CRC stage with `pause` while a stuffed bit is emitted, and forwards packet start/end framing aligned to the stuffed stream.

Parameters:
- MAX_ONES, 6, run length of consecutive 1s that triggers a stuffed 0 (USB: 6).
- CNT_W, 6, width of the per-packet stuffed-bit counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-high reset (asserted = 1 resets).
- s_in  input  1  serial data bit from CRC stage.
- start_b  input  1  pulse with first bit of packet on s_in.
- endr_b  input  1  pulse with last bit of packet on s_in.
- pause  output  1  to CRC stage: 1 = hold s_in, bit not consumed this cycle.
- s_out  output  1  stuffed serial bit to NRZI.
- out_valid  output  1  s_out carries a packet bit this cycle.
- start_o  output  1  pulse with first output bit of packet.
- endr_o  output  1  pulse with final output bit of packet (including a trailing stuffed 0).
- stuff_cnt  output  CNT_W  number of 0s stuffed in current/last packet; saturates at all-ones.
- err  output  1  1-cycle pulse: start_b seen while a packet is in progress.

Behaviour:
- Reset: state=IDLE, ones=0, s_out=0, out_valid=0, start_o=0, endr_o=0, stuff_cnt=0, err=0, last=0. `pause` is Moore and reads 0 in reset.
- Registered outputs give 1-cycle latency: a bit consumed in cycle t appears on s_out in cycle t+1.
- A bit is consumed in any cycle where state ∈ {IDLE with start_b, SEND} and pause=0.
- States:
  - IDLE
    - out_valid=0.
    - On start_b: consume s_in, start_o=1 next cycle, stuff_cnt cleared to 0, ones = s_in.
    - Next state per the SEND rules below (the first bit may also be the last).
  - SEND
    - Consume s_in each cycle.
    - Bit=1 → ones+1. Bit=0 → ones=0.
    - If the new ones == MAX_ONES → STUFF, with last=endr_b.
    - Else if endr_b → IDLE, endr_o=1 with that bit.
    - Else stay in SEND.
  - STUFF
    - pause=1; s_in ignored and held by upstream.
    - Next cycle: s_out=0, out_valid=1, ones=0, stuff_cnt+1 (saturating).
    - If last: endr_o=1 on the stuffed 0, go IDLE. Else go SEND.
- Timing example:
  - 6th consecutive 1 consumed at t; s_out=1 at t+1 with pause=1.
  - Stuffed 0 on s_out at t+2; next data bit consumed at t+2.
- Run counting spans the whole packet, including SYNC and CRC bits. ones resets at every packet start.
- start_b and endr_b in the same cycle: 1-bit packet, start_o and endr_o both asserted with that bit (plus stuffing rules, unreachable for MAX_ONES>1).
- start_b in SEND or STUFF: ignored for data, err=1 next cycle, current packet continues.
- endr_b while in STUFF: ignored (upstream is holding).
- endr_b in IDLE without start_b: ignored.
- Reset mid-packet (any state): immediate return to reset values. No endr_o is generated.
- stuff_cnt holds its value after the packet until the next start_b.

Test Plan:
- SYNC 0000_0001 (start_b on first bit, endr_b on last) → s_out 00000001 at t+1..t+8, pause never 1, stuff_cnt=0, endr_o on 8th output.
- Packet 1111_1111 → s_out 1111110 11 (9 bits), pause=1 exactly one cycle (output cycle 6), stuff_cnt=1.
- Twelve 1s → output 1111110 1111110 (14 bits), stuffed 0s at output positions 7 and 14; endr_o on position 14 with the stuffed 0; stuff_cnt=2.
- Pattern 11111011111 1 → first run broken by 0, no stuff there; second run of six 1s → one stuff; total output 13 bits.
- start_b reasserted mid-packet → err pulse 1 cycle later, output stream unchanged. Then rst_n=1 during STUFF → outputs, pause, and stuff_cnt are all 0 in the same cycle; the next packet stuffs correctly.
